// File: rtl/pipe_ctrl_if.sv
// Decode/EX sequencing bundle between the decode stage and pipe_ctrl.
// master drives decode state and EX resolution; slave returns issue decisions.
interface pipe_ctrl_if;
  logic       dec_valid;
  logic [2:0] dec_rs1;
  logic [2:0] dec_rs2;
  logic       dec_rs1_used;
  logic       dec_rs2_used;
  logic       dec_wr;
  logic [2:0] dec_rd;
  logic       dec_halt;
  logic       ex_taken;
  logic       resume;
  logic       issue;
  logic       stall;
  logic       flush;
  logic       halted;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  modport master (
    output dec_valid, dec_rs1, dec_rs2,
    output dec_rs1_used, dec_rs2_used,
    output dec_wr, dec_rd, dec_halt,
    output ex_taken, resume,
    input  issue, stall, flush, halted,
    input  fwd_a, fwd_b
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs2,
    input  dec_rs1_used, dec_rs2_used,
    input  dec_wr, dec_rd, dec_halt,
    input  ex_taken, resume,
    output issue, stall, flush, halted,
    output fwd_a, fwd_b
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Issue/stall/flush sequencing, RAW scoreboard and halt drain for the core.
// Define PIPE_CTRL_FWD_EN to forward from slots 1.. instead of stalling.
module pipe_ctrl #(
  parameter int WB_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [1:0]        cnt;
  logic [1:0]        cnt_nx;
  logic [WB_LAT-1:0] sb_v;
  logic [2:0]        sb_rd [WB_LAT];
  logic [WB_LAT-1:0] m_a;
  logic [WB_LAT-1:0] m_b;
  logic              hazard;

  always_comb begin
    m_a = '0;
    m_b = '0;
    for (int i = 0; i < WB_LAT; i++) begin
      m_a[i] = bus.dec_rs1_used && sb_v[i]
               && (sb_rd[i] == bus.dec_rs1);
      m_b[i] = bus.dec_rs2_used && sb_v[i]
               && (sb_rd[i] == bus.dec_rs2);
    end
  end

`ifdef PIPE_CTRL_FWD_EN
  // Descending scan so the youngest matching slot wins.
  always_comb begin
    hazard    = m_a[0] | m_b[0];
    bus.fwd_a = '0;
    bus.fwd_b = '0;
    for (int k = WB_LAT - 1; k >= 1; k--) begin
      if (m_a[k]) bus.fwd_a = 2'(k);
      if (m_b[k]) bus.fwd_b = 2'(k);
    end
  end
`else
  assign hazard    = (|m_a) | (|m_b);
  assign bus.fwd_a = '0;
  assign bus.fwd_b = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    bus.issue = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.ex_taken) begin
          bus.flush = 1'b1;
        end else if (!bus.dec_valid) begin
          bus.issue = 1'b0;
        end else if (hazard) begin
          bus.stall = 1'b1;
        end else begin
          bus.issue = 1'b1;
          if (bus.dec_halt) begin
            state_nx = DRAIN;
            cnt_nx   = 2'(WB_LAT);
          end
        end
      end
      DRAIN: begin
        bus.stall = 1'b1;
        if (cnt <= 2'd1) begin
          state_nx = HALTED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      HALTED: begin
        bus.stall = 1'b1;
        if (bus.resume) state_nx = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  assign bus.halted = (state == HALTED);

  // Slot 0 is EX; the oldest slot falls off the end each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_v <= '0;
      for (int i = 0; i < WB_LAT; i++) sb_rd[i] <= '0;
    end else begin
      sb_v     <= {sb_v[WB_LAT-2:0], bus.issue & bus.dec_wr};
      sb_rd[0] <= bus.dec_rd;
      for (int i = 1; i < WB_LAT; i++) sb_rd[i] <= sb_rd[i-1];
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against an in-flight-write list model.
// Works with or without PIPE_CTRL_FWD_EN defined.
module tb_pipe_ctrl;

  localparam int WB_LAT = 3;
`ifdef PIPE_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  pipe_ctrl_if bus ();

  pipe_ctrl #(.WB_LAT(WB_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] rd;
    int         c;
  } wr_t;

  wr_t        wq[$];
  int         cyc;
  bit         m_halting;
  int         h;
  bit         e_issue, e_stall, e_flush, e_halted, e_fwd_chk;
  logic [1:0] e_fwd_a, e_fwd_b;
  int         n_chk;
  int         n_fail;

  task automatic model_clear();
    wq.delete();
    m_halting = 1'b0;
    h = 0;
  endtask

  // A write issued in cycle c sits in slot (now - c - 1) until it ages out.
  task automatic model_eval();
    bit m0, hz, ma, mb;
    int ba, bb, s;
    m0 = 0; hz = 0; ba = 99; bb = 99;
    foreach (wq[j]) begin
      s  = cyc - wq[j].c - 1;
      ma = bus.dec_rs1_used && (bus.dec_rs1 == wq[j].rd);
      mb = bus.dec_rs2_used && (bus.dec_rs2 == wq[j].rd);
      if (s >= 0 && s < WB_LAT && (ma || mb)) begin
        if (s == 0) m0 = 1;
        if (!FWD || s == 0) hz = 1;
        if (FWD && s > 0 && ma && s < ba) ba = s;
        if (FWD && s > 0 && mb && s < bb) bb = s;
      end
    end
    e_fwd_a   = (ba == 99) ? 2'd0 : 2'(ba);
    e_fwd_b   = (bb == 99) ? 2'd0 : 2'(bb);
    e_fwd_chk = !FWD || !m0;
    e_issue = 0; e_stall = 0; e_flush = 0; e_halted = 0;
    if (m_halting) begin
      e_stall  = 1;
      e_halted = (cyc >= h + WB_LAT + 1);
    end else if (bus.ex_taken) begin
      e_flush = 1;
    end else if (!bus.dec_valid) begin
      e_issue = 0;
    end else if (hz) begin
      e_stall = 1;
    end else begin
      e_issue = 1;
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] r1,
                       input bit u1, input logic [2:0] r2,
                       input bit u2, input bit wr,
                       input logic [2:0] rd, input bit hlt,
                       input bit tk, input bit res);
    bus.dec_valid    = v;
    bus.dec_rs1      = r1;
    bus.dec_rs1_used = u1;
    bus.dec_rs2      = r2;
    bus.dec_rs2_used = u2;
    bus.dec_wr       = wr;
    bus.dec_rd       = rd;
    bus.dec_halt     = hlt;
    bus.ex_taken     = tk;
    bus.resume       = res;
    model_eval();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    bit wr, hlt, res;
    logic [2:0] rd;
    wr  = bus.dec_wr;
    hlt = bus.dec_halt;
    res = bus.resume;
    rd  = bus.dec_rd;
    @(posedge clk);
    #1;
    if (rst) begin
      model_clear();
    end else begin
      if (e_issue && wr) wq.push_back('{rd, cyc});
      if (e_issue && hlt) begin
        m_halting = 1;
        h = cyc;
      end else if (m_halting && e_halted && res) begin
        m_halting = 0;
      end
    end
    cyc++;
    while (wq.size() > 0 && cyc - wq[0].c - 1 >= WB_LAT)
      void'(wq.pop_front());
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      idle();
      tick();
    end
  endtask

  task automatic test_reset();
    idle();
    #2;
    n_chk++;
    if ({bus.issue, bus.stall, bus.flush, bus.halted} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 0000",
               {bus.issue, bus.stall, bus.flush, bus.halted});
    end
    n_chk++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_fwd: got %b expected 0000",
               {bus.fwd_a, bus.fwd_b});
    end
    @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    cyc = 0;
    drive(1, 3'd1, 1, 3'd2, 1, 0, 0, 0, 0, 0);
    #3;
    n_chk++;
    if ({bus.issue, bus.stall} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_issue: got %b expected 10",
               {bus.issue, bus.stall});
    end
    tick();
  endtask

  task automatic test_raw();
    int  stalls;
    bit  issued;
    logic [1:0] fa;
    stalls = 0; issued = 0; fa = 0;
    drive(1, 0, 0, 0, 0, 1, 3'd2, 0, 0, 0);
    #3;
    n_chk++;
    if (bus.issue !== 1'b1) begin
      n_fail++;
      $display("FAIL raw_producer: issue=%b expected 1", bus.issue);
    end
    tick();
    for (int i = 0; i < 6 && !issued; i++) begin
      drive(1, 3'd2, 1, 0, 0, 1, 3'd1, 0, 0, 0);
      #3;
      n_chk++;
      if ({bus.issue, bus.stall, bus.flush} !==
          {e_issue, e_stall, e_flush}) begin
        n_fail++;
        $display("FAIL raw_cycle%0d: got %b expected %b", i,
                 {bus.issue, bus.stall, bus.flush},
                 {e_issue, e_stall, e_flush});
      end
      if (bus.issue) begin
        issued = 1;
        fa = bus.fwd_a;
      end else if (bus.stall) begin
        stalls++;
      end
      tick();
    end
    n_chk++;
    if (!issued || stalls != (FWD ? 1 : 3)) begin
      n_fail++;
      $display("FAIL raw_stall_len: issued=%0d stalls=%0d expected %0d",
               issued, stalls, FWD ? 1 : 3);
    end
    n_chk++;
    if (fa !== (FWD ? 2'd1 : 2'd0)) begin
      n_fail++;
      $display("FAIL raw_fwd_a: got %0d expected %0d", fa, FWD ? 1 : 0);
    end
    settle(4);
  endtask

  task automatic test_fwd_select();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 0, 1, 3'd5, 0, 0, 0);
      #3;
      n_chk++;
      if (bus.issue !== 1'b1) begin
        n_fail++;
        $display("FAIL fwdsel_writer%0d: issue=%b expected 1",
                 i, bus.issue);
      end
      tick();
    end
    settle(1);
    drive(1, 0, 0, 3'd5, 1, 0, 0, 0, 0, 0);
    #3;
    n_chk++;
    if ({bus.issue, bus.stall} !== (FWD ? 2'b10 : 2'b01)) begin
      n_fail++;
      $display("FAIL fwdsel_ctl: got %b expected %b",
               {bus.issue, bus.stall}, FWD ? 2'b10 : 2'b01);
    end
    n_chk++;
    if (bus.fwd_b !== (FWD ? 2'd1 : 2'd0)) begin
      n_fail++;
      $display("FAIL fwdsel_youngest: fwd_b=%0d expected %0d",
               bus.fwd_b, FWD ? 1 : 0);
    end
    tick();
    settle(4);
  endtask

  task automatic test_branch();
    drive(1, 0, 0, 0, 0, 1, 3'd4, 0, 0, 0);
    tick();
    drive(1, 3'd4, 1, 0, 0, 1, 3'd6, 0, 1, 0);
    #3;
    n_chk++;
    if ({bus.issue, bus.stall, bus.flush} !== 3'b001) begin
      n_fail++;
      $display("FAIL branch_flush: got %b expected 001",
               {bus.issue, bus.stall, bus.flush});
    end
    tick();
    drive(1, 3'd6, 1, 0, 0, 0, 0, 0, 0, 0);
    #3;
    n_chk++;
    if ({bus.issue, bus.stall, bus.flush} !== 3'b100) begin
      n_fail++;
      $display("FAIL branch_bubble: got %b expected 100",
               {bus.issue, bus.stall, bus.flush});
    end
    tick();
    settle(4);
  endtask

  task automatic test_halt();
    bit xi, xs, xh;
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    #3;
    n_chk++;
    if ({bus.issue, bus.stall} !== 2'b10) begin
      n_fail++;
      $display("FAIL halt_issue: got %b expected 10",
               {bus.issue, bus.stall});
    end
    tick();
    for (int k = 1; k <= 11; k++) begin
      if (k == 2 || k == 10) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      else if (k == 11) drive(1, 0, 0, 0, 0, 1, 3'd1, 0, 0, 0);
      else idle();
      #3;
      xi = (k == 11);
      xs = (k <= 10);
      xh = (k >= WB_LAT + 1) && (k <= 10);
      n_chk++;
      if ({bus.issue, bus.stall, bus.halted} !== {xi, xs, xh}) begin
        n_fail++;
        $display("FAIL halt_t+%0d: got %b expected %b", k,
                 {bus.issue, bus.stall, bus.halted}, {xi, xs, xh});
      end
      tick();
    end
    settle(4);
  endtask

  task automatic test_halt_flush();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    #3;
    n_chk++;
    if ({bus.issue, bus.stall, bus.flush} !== 3'b001) begin
      n_fail++;
      $display("FAIL haltflush_ctl: got %b expected 001",
               {bus.issue, bus.stall, bus.flush});
    end
    tick();
    for (int k = 1; k <= 6; k++) begin
      idle();
      #3;
      n_chk++;
      if ({bus.stall, bus.halted} !== 2'b00) begin
        n_fail++;
        $display("FAIL haltflush_t+%0d: stall/halted=%b expected 00",
                 k, {bus.stall, bus.halted});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 0, 0, 1, 3'd3, 0, 0, 0);
    tick();
    drive(1, 3'd3, 1, 0, 0, 0, 0, 0, 0, 0);
    #3;
    n_chk++;
    if (bus.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: stall=%b expected 1", bus.stall);
    end
    #1;
    rst = 1;
    #1;
    n_chk++;
    if ({bus.stall, bus.halted, bus.flush} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b expected 000",
               {bus.stall, bus.halted, bus.flush});
    end
    model_clear();
    tick();
    rst = 0;
    drive(1, 3'd3, 1, 0, 0, 0, 0, 0, 0, 0);
    #3;
    n_chk++;
    if ({bus.issue, bus.stall} !== 2'b10) begin
      n_fail++;
      $display("FAIL rstmid_reader: got %b expected 10",
               {bus.issue, bus.stall});
    end
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    idle();
    tick();
    #3;
    n_chk++;
    if (bus.stall !== 1'b1) begin
      n_fail++;
      $display("FAIL rstdrain_pre: stall=%b expected 1", bus.stall);
    end
    rst = 1;
    #1;
    n_chk++;
    if ({bus.stall, bus.halted} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstdrain_async: got %b expected 00",
               {bus.stall, bus.halted});
    end
    model_clear();
    tick();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      idle();
      #3;
      n_chk++;
      if ({bus.stall, bus.halted} !== 2'b00) begin
        n_fail++;
        $display("FAIL rstdrain_after%0d: got %b expected 00",
                 k, {bus.stall, bus.halted});
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit v, u1, u2, wr, hl, tk, rs;
    logic [2:0] r1, r2, rd;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      r1 = 3'($urandom_range(0, 3));
      r2 = 3'($urandom_range(0, 3));
      u1 = 1'($urandom_range(0, 1));
      u2 = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      rd = 3'($urandom_range(0, 3));
      hl = ($urandom_range(0, 39) == 0);
      tk = !m_halting && ($urandom_range(0, 7) == 0);
      rs = m_halting && ($urandom_range(0, 3) == 0);
      drive(v, r1, u1, r2, u2, wr, rd, hl, tk, rs);
      #3;
      n_chk++;
      if ({bus.issue, bus.stall, bus.flush, bus.halted} !==
          {e_issue, e_stall, e_flush, e_halted}) begin
        n_fail++;
        $display("FAIL rand%0d_ctl: got %b expected %b", i,
                 {bus.issue, bus.stall, bus.flush, bus.halted},
                 {e_issue, e_stall, e_flush, e_halted});
      end
      if (e_fwd_chk) begin
        n_chk++;
        if ({bus.fwd_a, bus.fwd_b} !== {e_fwd_a, e_fwd_b}) begin
          n_fail++;
          $display("FAIL rand%0d_fwd: got %0d/%0d expected %0d/%0d",
                   i, bus.fwd_a, bus.fwd_b, e_fwd_a, e_fwd_b);
        end
      end
      tick();
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    rst    = 1;
    model_clear();
    idle();
    test_reset();
    test_raw();
    test_fwd_select();
    test_branch();
    test_halt();
    test_halt_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
